// File: rtl/instr_word_encoder_if.sv
// Field-tuple handshake and instruction-memory write port of the word encoder.
// master = loader/harness side, slave = encoder side.
interface instr_word_encoder_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_fmt;
  logic [4:0]        in_opcode;
  logic [4:0]        in_dirw;
  logic [4:0]        in_rega;
  logic [4:0]        in_regb;
  logic [15:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, in_fmt, in_opcode, in_dirw, in_rega, in_regb, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_dirw, in_rega, in_regb, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_word_encoder.sv
// Packs decoded instruction fields into 32-bit words, buffers them in a small
// show-ahead FIFO and writes them to instruction memory at auto-incrementing addresses.
module instr_word_encoder #(
  parameter int ADDR_W     = 8,
  parameter int MAX_WORDS  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic [ADDR_W-1:0] base_addr,
  instr_word_encoder_if.slave bus,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              limit_hit
);
  // state | meaning
  // IDLE  | no session; start opens one
  // LOAD  | accepting tuples and writing buffered words
  // DRAIN | finish seen; writing out remaining words, then back to IDLE
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ACC_W = $clog2(MAX_WORDS + 1);
  localparam logic [PTR_W:0]   FULL_CNT = FIFO_DEPTH[PTR_W:0];
  localparam logic [ACC_W-1:0] ACC_MAX  = MAX_WORDS[ACC_W-1:0];
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_MAX - 1'b1;

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic [ACC_W-1:0]  accepted;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       enc_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // bits[15:12] are regb for R-type but imm for I-type; in_fmt alone decides
  always_comb begin
    if (bus.in_fmt)
      enc_word = {bus.in_opcode, bus.in_dirw, bus.in_rega, 1'b0, bus.in_imm};
    else
      enc_word = {bus.in_opcode, bus.in_dirw, bus.in_rega, bus.in_regb, 12'b0};
  end

  assign fifo_empty    = (fifo_cnt == '0);
  assign fifo_full     = (fifo_cnt == FULL_CNT);
  assign bus.in_ready  = (state == LOAD) && !fifo_full && (accepted < ACC_MAX);
  assign bus.mem_we    = (state != IDLE) && !fifo_empty;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = fifo_mem[rd_ptr];
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.mem_we && bus.mem_ready;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      word_count <= '0;
      accepted   <= '0;
      limit_hit  <= 1'b0;
      done       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // restart discards anything still buffered, including a same-cycle write
        state      <= LOAD;
        addr_q     <= base_addr;
        word_count <= '0;
        accepted   <= '0;
        limit_hit  <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_cnt   <= '0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= enc_word;
          wr_ptr           <= wr_ptr + 1'b1;
          accepted         <= accepted + 1'b1;
          if (accepted == ACC_LAST) limit_hit <= 1'b1;
        end
        if (pop) begin
          rd_ptr     <= rd_ptr + 1'b1;
          addr_q     <= addr_q + 1'b1;
          word_count <= word_count + 1'b1;
        end
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: ;
        endcase
        case (state)
          IDLE: ;
          LOAD: if (finish) state <= DRAIN;
          DRAIN: begin
            if (fifo_empty) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder: stimulus pushes expected writes into
// per-DUT queues, a monitor pops them as the memory port accepts words.
module tb_instr_word_encoder;
  logic       clk;
  logic       rst_n;
  logic       start_a, finish_a, start_b, finish_b;
  logic [7:0] base_a, base_b;
  logic [8:0] word_count_a, word_count_b;
  logic       busy_a, busy_b, done_a, done_b, limit_hit_a, limit_hit_b;

  instr_word_encoder_if #(.ADDR_W(8)) ifa ();
  instr_word_encoder_if #(.ADDR_W(8)) ifb ();

  instr_word_encoder #(.ADDR_W(8), .MAX_WORDS(256), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .finish(finish_a), .base_addr(base_a),
    .bus(ifa), .word_count(word_count_a), .busy(busy_a), .done(done_a),
    .limit_hit(limit_hit_a)
  );

  instr_word_encoder #(.ADDR_W(8), .MAX_WORDS(4), .FIFO_DEPTH(4)) u_lim (
    .clk(clk), .rst_n(rst_n), .start(start_b), .finish(finish_b), .base_addr(base_b),
    .bus(ifb), .word_count(word_count_b), .busy(busy_b), .done(done_b),
    .limit_hit(limit_hit_b)
  );

  typedef struct {
    bit        fmt;
    bit [4:0]  op, dirw, rega, regb;
    bit [15:0] imm;
    bit [31:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs [8];
  wr_t  q_a [$];
  wr_t  q_b [$];
  logic [7:0] addr_a, addr_b;
  int n_pass = 0;
  int n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void mon_check(input int sel);
    wr_t e;
    logic [7:0]  a;
    logic [31:0] d;
    a = (sel == 0) ? ifa.mem_addr : ifb.mem_addr;
    d = (sel == 0) ? ifa.mem_wdata : ifb.mem_wdata;
    if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
      n_total++;
      $display("FAIL unexpected_write dut%0d: got addr %h data %h expected no write", sel, a, d);
    end else begin
      e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
      chk($sformatf("wr_addr dut%0d", sel), 32'(a), 32'(e.addr));
      chk($sformatf("wr_data dut%0d", sel), d, e.data);
    end
  endfunction

  always @(negedge clk) begin
    #2;
    if (ifa.mem_we && ifa.mem_ready) mon_check(0);
    if (ifb.mem_we && ifb.mem_ready) mon_check(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input bit fmt, input bit [4:0] op, input bit [4:0] dirw,
                              input bit [4:0] rega, input bit [4:0] regb,
                              input bit [15:0] imm, input bit [31:0] exp);
    vec_t v;
    v.fmt = fmt; v.op = op; v.dirw = dirw; v.rega = rega; v.regb = regb;
    v.imm = imm; v.exp = exp;
    return v;
  endfunction

  task automatic drive_fields(input int sel, input vec_t v, input logic valid);
    if (sel == 0) begin
      ifa.in_valid = valid; ifa.in_fmt = v.fmt; ifa.in_opcode = v.op; ifa.in_dirw = v.dirw;
      ifa.in_rega = v.rega; ifa.in_regb = v.regb; ifa.in_imm = v.imm;
    end else begin
      ifb.in_valid = valid; ifb.in_fmt = v.fmt; ifb.in_opcode = v.op; ifb.in_dirw = v.dirw;
      ifb.in_rega = v.rega; ifb.in_regb = v.regb; ifb.in_imm = v.imm;
    end
  endtask

  // called at a negedge; returns at a negedge
  task automatic send(input int sel, input int idx, input int budget, output bit ok);
    vec_t v;
    v = vecs[idx];
    drive_fields(sel, v, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      if ((sel == 0) ? ifa.in_ready : ifb.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        if (sel == 0) begin q_a.push_back('{addr_a, v.exp}); addr_a++; end
        else          begin q_b.push_back('{addr_b, v.exp}); addr_b++; end
      end
      @(negedge clk);
    end
    drive_fields(sel, v, 1'b0);
  endtask

  task automatic send_ok(input int sel, input int idx);
    bit ok;
    send(sel, idx, 20, ok);
    chk($sformatf("accept dut%0d vec%0d", sel, idx), 32'(ok), 32'd1);
  endtask

  task automatic pulse_start(input int sel, input logic [7:0] base);
    if (sel == 0) begin base_a = base; start_a = 1'b1; q_a.delete(); addr_a = base; end
    else          begin base_b = base; start_b = 1'b1; q_b.delete(); addr_b = base; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic pulse_finish(input int sel);
    if (sel == 0) finish_a = 1'b1; else finish_b = 1'b1;
    @(negedge clk);
    finish_a = 1'b0;
    finish_b = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((sel == 0) ? done_a : done_b) seen++;
    end
    chk($sformatf("done_pulses dut%0d", sel), 32'(seen), 32'd1);
    chk($sformatf("busy_after_done dut%0d", sel), 32'((sel == 0) ? busy_a : busy_b), 32'd0);
  endtask

  initial begin
    bit ok;
    vec_t z;
    vecs[0] = mk(1'b0, 5'd3,  5'd4,  5'd1,  5'd2,  16'h0000, 32'h19022000);
    vecs[1] = mk(1'b1, 5'd10, 5'd7,  5'd3,  5'd31, 16'hBEEF, 32'h51C6BEEF);
    vecs[2] = mk(1'b0, 5'd1,  5'd1,  5'd1,  5'd1,  16'h0000, 32'h08421000);
    vecs[3] = mk(1'b1, 5'd2,  5'd2,  5'd2,  5'd0,  16'h1234, 32'h10841234);
    vecs[4] = mk(1'b0, 5'd31, 5'd31, 5'd31, 5'd31, 16'h0000, 32'hFFFFF000);
    vecs[5] = mk(1'b1, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 32'hFFFEFFFF);
    vecs[6] = mk(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  16'hFFFF, 32'h00000000);
    vecs[7] = mk(1'b1, 5'd0,  5'd0,  5'd0,  5'd31, 16'h0001, 32'h00000001);
    z = mk(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0);
    drive_fields(0, z, 1'b0);
    drive_fields(1, z, 1'b0);
    ifa.mem_ready = 1'b0; ifb.mem_ready = 1'b0;
    start_a = 1'b0; finish_a = 1'b0; start_b = 1'b0; finish_b = 1'b0;
    base_a = '0; base_b = '0; addr_a = '0; addr_b = '0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst in_ready",   32'(ifa.in_ready),  32'd0);
    chk("rst mem_we",     32'(ifa.mem_we),    32'd0);
    chk("rst mem_addr",   32'(ifa.mem_addr),  32'd0);
    chk("rst mem_wdata",  ifa.mem_wdata,      32'd0);
    chk("rst word_count", 32'(word_count_a),  32'd0);
    chk("rst busy",       32'(busy_a),        32'd0);
    chk("rst done",       32'(done_a),        32'd0);
    chk("rst limit_hit",  32'(limit_hit_b),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // finish while idle has no effect
    pulse_finish(0);
    chk("idle_finish busy", 32'(busy_a), 32'd0);
    chk("idle_finish done", 32'(done_a), 32'd0);

    // R-type then I-type with latency check
    pulse_start(0, 8'h10);
    chk("start busy",     32'(busy_a),        32'd1);
    chk("start in_ready", 32'(ifa.in_ready),  32'd1);
    chk("start mem_addr", 32'(ifa.mem_addr),  32'h10);
    ifa.mem_ready = 1'b1;
    send_ok(0, 0);
    chk("rtype mem_we",    32'(ifa.mem_we),   32'd1);
    chk("rtype mem_addr",  32'(ifa.mem_addr), 32'h10);
    chk("rtype mem_wdata", ifa.mem_wdata,     32'h19022000);
    @(negedge clk);
    chk("rtype word_count", 32'(word_count_a), 32'd1);
    send_ok(0, 1);
    chk("itype mem_wdata", ifa.mem_wdata, 32'h51C6BEEF);
    @(negedge clk);
    chk("itype word_count", 32'(word_count_a), 32'd2);
    chk("itype mem_addr",   32'(ifa.mem_addr), 32'h12);

    // backpressure: FIFO fills at 4, head word and address hold
    ifa.mem_ready = 1'b0;
    for (int i = 2; i < 6; i++) send_ok(0, i);
    chk("full in_ready", 32'(ifa.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("hold mem_wdata", ifa.mem_wdata,     32'h08421000);
      chk("hold mem_addr",  32'(ifa.mem_addr), 32'h12);
      @(negedge clk);
    end
    send(0, 6, 3, ok);
    chk("full reject", 32'(ok), 32'd0);
    ifa.mem_ready = 1'b1;
    send_ok(0, 6);
    send_ok(0, 7);
    repeat (8) @(negedge clk);
    chk("bp word_count", 32'(word_count_a), 32'd8);
    chk("bp mem_we",     32'(ifa.mem_we),   32'd0);

    // finish with 3 queued words
    ifa.mem_ready = 1'b0;
    send_ok(0, 0);
    send_ok(0, 1);
    send_ok(0, 4);
    pulse_finish(0);
    chk("drain in_ready", 32'(ifa.in_ready), 32'd0);
    chk("drain busy",     32'(busy_a),       32'd1);
    chk("drain mem_we",   32'(ifa.mem_we),   32'd1);
    ifa.mem_ready = 1'b1;
    wait_done(0);
    chk("drain word_count", 32'(word_count_a), 32'd11);

    // limit and address wrap on the MAX_WORDS=4 instance
    pulse_start(1, 8'hFE);
    ifb.mem_ready = 1'b1;
    send_ok(1, 2);
    send_ok(1, 3);
    send_ok(1, 4);
    chk("lim before limit_hit", 32'(limit_hit_b), 32'd0);
    send_ok(1, 5);
    chk("lim in_ready",  32'(ifb.in_ready), 32'd0);
    chk("lim limit_hit", 32'(limit_hit_b),  32'd1);
    send(1, 6, 5, ok);
    chk("lim fifth rejected", 32'(ok), 32'd0);
    repeat (4) @(negedge clk);
    chk("lim word_count", 32'(word_count_b),  32'd4);
    chk("lim mem_addr",   32'(ifb.mem_addr),  32'h02);
    chk("lim still_hit",  32'(limit_hit_b),   32'd1);
    pulse_finish(1);
    wait_done(1);

    // asynchronous reset with words pending
    pulse_start(0, 8'h40);
    send_ok(0, 0);
    repeat (2) @(negedge clk);
    chk("pre_rst word_count", 32'(word_count_a), 32'd1);
    ifa.mem_ready = 1'b0;
    send_ok(0, 1);
    send_ok(0, 2);
    chk("pre_rst mem_we", 32'(ifa.mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst mem_we",     32'(ifa.mem_we),    32'd0);
    chk("async_rst word_count", 32'(word_count_a),  32'd0);
    chk("async_rst mem_addr",   32'(ifa.mem_addr),  32'd0);
    chk("async_rst busy",       32'(busy_a),        32'd0);
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // restart mid-LOAD flushes queued words
    pulse_start(0, 8'h80);
    send_ok(0, 3);
    send_ok(0, 4);
    chk("pre_restart mem_addr", 32'(ifa.mem_addr), 32'h80);
    pulse_start(0, 8'hC0);
    chk("restart mem_we",     32'(ifa.mem_we),    32'd0);
    chk("restart mem_addr",   32'(ifa.mem_addr),  32'hC0);
    chk("restart in_ready",   32'(ifa.in_ready),  32'd1);
    ifa.mem_ready = 1'b1;
    send_ok(0, 1);
    repeat (2) @(negedge clk);
    chk("restart word_count", 32'(word_count_a), 32'd1);
    chk("restart next_addr",  32'(ifa.mem_addr), 32'hC1);
    pulse_finish(0);
    wait_done(0);

    chk("scoreboard a empty", 32'(q_a.size()), 32'd0);
    chk("scoreboard b empty", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
